plot_sink: RTL and testbench

- Receiving end of the pixel-plot interface. Accepts {x, y, colour} plot requests from UI drawing blocks through a valid/ready handshake and buffers them in a small FIFO.
- Clips out-of-range coordinates and linearises each accepted pixel to a 160x120 framebuffer address, one write per cycle.
- Also provides a hardware clear-screen sweep.
- Sits between the UI drawing datapaths and the framebuffer write port.

---
 rtl/plot_sink_pkg.sv | 42 ++++
 rtl/plot_sink_fifo.sv | 63 ++++++
 rtl/plot_sink.sv | 171 +++++++++++++++++
 tb/tb_plot_sink.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_sink_pkg.sv
// plot_sink_pkg: framebuffer geometry, request format and controller states
// shared by the plot sink and its request FIFO.
package plot_sink_pkg;

  localparam int H_RES          = 160;
  localparam int V_RES          = 120;
  localparam int FB_SIZE        = H_RES * V_RES;
  localparam int ADDR_W         = 15;
  localparam int COLOUR_W       = 3;
  localparam int X_W            = 8;
  localparam int Y_W            = 7;
  localparam int REQ_W          = X_W + Y_W + COLOUR_W;
  localparam int FIFO_DEPTH_DEF = 4;

  // Typed limits, so that comparisons happen at the coordinate widths.
  localparam logic [X_W-1:0]    H_RES_X = 8'd160;
  localparam logic [Y_W-1:0]    V_RES_Y = 7'd120;
  localparam logic [ADDR_W-1:0] FB_LAST = 15'd19199;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_req_t;

  // Row-major address y*160 + x, built from shifts (160 = 128 + 32).
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] x_w;
    logic [ADDR_W-1:0] y_w;
    x_w = {{(ADDR_W - X_W){1'b0}}, x};
    y_w = {{(ADDR_W - Y_W){1'b0}}, y};
    return (y_w << 3'd7) + (y_w << 3'd5) + x_w;
  endfunction

endpackage

// File: rtl/plot_sink_fifo.sv
// plot_fifo: small synchronous FIFO for plot requests. Push is ignored when
// full and pop is ignored when empty. DEPTH must be a power of two (>= 2).
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(PTR_W + 1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointers and occupancy; simultaneous push and pop leave the count as is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/plot_sink.sv
// plot_sink: accepts {x, y, colour} plot requests over valid/ready, queues
// them, clips out-of-range pixels and writes the rest to a 160x120
// framebuffer. A clear request drains the queue and then sweeps every
// address with a fill colour.
// Optional build macro PLOT_SINK_CLIP_COUNT_EN adds a saturating clip_count.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                plot_valid,
  output logic                plot_ready,
  input  logic [X_W-1:0]      plot_x,
  input  logic [Y_W-1:0]      plot_y,
  input  logic [COLOUR_W-1:0] plot_colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  input  logic                fb_stall,
  output logic                fb_we,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_wdata
`ifdef PLOT_SINK_CLIP_COUNT_EN
  ,
  output logic [15:0]         clip_count
`endif
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [ADDR_W-1:0]   clr_cnt_nxt_s;
  logic [COLOUR_W-1:0] clr_colour_r;
  logic [REQ_W-1:0]    push_data_s;
  logic [REQ_W-1:0]    head_data_s;
  plot_req_t           head_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic                in_range_s;

  // Ready depends on registered state only, never on plot_valid.
  assign plot_ready  = (state_r == ST_RUN) && !full_s;
  assign clear_busy  = (state_r != ST_RUN);
  assign push_s      = plot_valid && plot_ready;
  assign push_data_s = {plot_x, plot_y, plot_colour};
  assign head_s      = plot_req_t'(head_data_s);
  // The queue keeps issuing through RUN and DRAIN; the sweep owns the port in CLEAR.
  assign pop_s       = (state_r != ST_CLEAR) && !empty_s && !fb_stall;
  assign in_range_s  = (head_s.x < H_RES_X) && (head_s.y < V_RES_Y);

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (push_data_s),
    .rdata   (head_data_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Controller state and sweep counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_RUN;
      clr_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next-state logic: RUN -> DRAIN on clear, DRAIN -> CLEAR once empty, CLEAR -> RUN after last address.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (clear_req) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (empty_s && !pop_s) begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (!fb_stall) begin
          if (clr_cnt_r == FB_LAST) begin
            state_nxt_s   = ST_RUN;
            clr_cnt_nxt_s = {ADDR_W{1'b0}};
          end else begin
            state_nxt_s   = ST_CLEAR;
            clr_cnt_nxt_s = clr_cnt_r + 15'd1;
          end
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s   = ST_RUN;
        clr_cnt_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Fill colour is captured only when a clear is accepted in RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clr_colour_r <= {COLOUR_W{1'b0}};
    end else if ((state_r == ST_RUN) && clear_req) begin
      clr_colour_r <= clear_colour;
    end else begin
      clr_colour_r <= clr_colour_r;
    end
  end

  // Registered framebuffer write port: sweep writes in CLEAR, queued pixels otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fb_we    <= 1'b0;
      fb_addr  <= {ADDR_W{1'b0}};
      fb_wdata <= {COLOUR_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      if (!fb_stall) begin
        fb_we    <= 1'b1;
        fb_addr  <= clr_cnt_r;
        fb_wdata <= clr_colour_r;
      end else begin
        fb_we <= 1'b0;
      end
    end else if (pop_s && in_range_s) begin
      fb_we    <= 1'b1;
      fb_addr  <= lin_addr(head_s.x, head_s.y);
      fb_wdata <= head_s.colour;
    end else begin
      fb_we <= 1'b0;
    end
  end

`ifdef PLOT_SINK_CLIP_COUNT_EN
  logic [15:0] clip_cnt_r;

  // Saturating count of popped requests that fell outside the screen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clip_cnt_r <= 16'd0;
    end else if (pop_s && !in_range_s && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'd1;
    end else begin
      clip_cnt_r <= clip_cnt_r;
    end
  end

  assign clip_count = clip_cnt_r;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: directed scenarios plus a randomized phase; every framebuffer
// write is matched against an ordered queue of expected (address, data)
// pairs derived from the accepted requests and clear sequences.
module tb_plot_sink;
  import plot_sink_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                plot_valid;
  logic                plot_ready;
  logic [X_W-1:0]      plot_x;
  logic [Y_W-1:0]      plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                clear_req;
  logic [COLOUR_W-1:0] clear_colour;
  logic                clear_busy;
  logic                fb_stall;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_wdata;
`ifdef PLOT_SINK_CLIP_COUNT_EN
  logic [15:0]         clip_count;
`endif

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  clip_model = 0;
  int  write_cnt = 0;

  always #5 clk = ~clk;

  plot_sink dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .plot_valid   (plot_valid),
    .plot_ready   (plot_ready),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .fb_stall     (fb_stall),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata)
`ifdef PLOT_SINK_CLIP_COUNT_EN
    ,
    .clip_count   (clip_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Monitor away from the active edge: record handshakes and score writes.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && plot_valid === 1'b1 && plot_ready === 1'b1) begin
      if (int'(plot_x) < H_RES && int'(plot_y) < V_RES) begin
        exp_q.push_back('{addr: int'(plot_y) * H_RES + int'(plot_x), data: int'(plot_colour)});
      end else begin
        clip_model++;
      end
    end
    if (fb_we === 1'b1) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: got addr=%0d data=%0d expected no write", fb_addr, fb_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(e.addr));
        chk("wr_data", 32'(fb_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until it is accepted (bounded).
  task automatic send(input int x, input int y, input int c);
    int n;
    n = 0;
    plot_x      = 8'(x);
    plot_y      = 7'(y);
    plot_colour = 3'(c);
    plot_valid  = 1'b1;
    while (plot_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: got ready=%b expected 1", plot_ready);
    end
    tick();
    plot_valid = 1'b0;
  endtask

  task automatic push_clear(input int c);
    for (int a = 0; a < FB_SIZE; a++) begin
      exp_q.push_back('{addr: a, data: c});
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    plot_valid = 1'b0;
    while ((exp_q.size() != 0 || clear_busy !== 1'b0) && n < 2000) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int cyc;
    int n;
    int wc0;
    logic rdy;

    reset_n      = 1'b0;
    plot_valid   = 1'b0;
    plot_x       = 8'd0;
    plot_y       = 7'd0;
    plot_colour  = 3'd0;
    clear_req    = 1'b0;
    clear_colour = 3'd0;
    fb_stall     = 1'b0;
    tick();
    tick();
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    chk("rst_ready", 32'(plot_ready), 32'd1);
    chk("rst_busy", 32'(clear_busy), 32'd0);
`ifdef PLOT_SINK_CLIP_COUNT_EN
    chk("rst_clip", 32'(clip_count), 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    // 1: single plot, two-cycle latency.
    chk("t1_ready", 32'(plot_ready), 32'd1);
    send(79, 63, 4);
    chk("t1_we_lat1", 32'(fb_we), 32'd0);
    tick();
    chk("t1_we", 32'(fb_we), 32'd1);
    chk("t1_addr", 32'(fb_addr), 32'd10159);
    chk("t1_data", 32'(fb_wdata), 32'd4);
    tick();
    chk("t1_we_once", 32'(fb_we), 32'd0);
    wait_drain("t1_drain");

    // 2: six back-to-back requests against a stalled port.
    fb_stall = 1'b1;
    acc = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 10) fb_stall = 1'b0;
      plot_valid  = (acc < 6);
      plot_x      = 8'(10 + acc);
      plot_y      = 7'(20 + acc);
      plot_colour = 3'(acc + 1);
      rdy = plot_ready;
      tick();
      if (rdy && plot_valid) acc++;
      if (c < 10) chk("t2_no_we_stalled", 32'(fb_we), 32'd0);
      if (c == 9) begin
        chk("t2_accepted_stalled", 32'(acc), 32'd4);
        chk("t2_ready_full", 32'(plot_ready), 32'd0);
      end
      if (c >= 10 && c < 14) chk("t2_we_burst", 32'(fb_we), 32'd1);
    end
    chk("t2_accepted_total", 32'(acc), 32'd6);
    wait_drain("t2_drain");

    // 3: clipping at both edges plus the last valid pixel.
    wc0 = write_cnt;
    send(160, 0, 1);
    send(0, 120, 2);
    send(159, 119, 5);
    tick();
    chk("t3_last_addr", 32'(fb_addr), 32'd19199);
    wait_drain("t3_drain");
    chk("t3_write_count", 32'(write_cnt - wc0), 32'd1);
`ifdef PLOT_SINK_CLIP_COUNT_EN
    chk("t3_clip", 32'(clip_count), 32'd2);
`endif

    // 4: queued plots before a black clear.
    fb_stall = 1'b1;
    send(1, 1, 7);
    send(2, 2, 6);
    send(3, 3, 5);
    clear_colour = 3'd0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_clear(0);
    chk("t4_busy", 32'(clear_busy), 32'd1);
    chk("t4_ready", 32'(plot_ready), 32'd0);
    fb_stall = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 25000) begin
      chk("t4_ready_low", 32'(plot_ready), 32'd0);
      tick();
      n++;
    end
    chk("t4_busy_fall_we", 32'(fb_we), 32'd1);
    chk("t4_busy_fall_addr", 32'(fb_addr), 32'd19199);
    chk("t4_busy_fall_data", 32'(fb_wdata), 32'd0);
    tick();
    chk("t4_all_written", 32'(exp_q.size()), 32'd0);

    // 5: sweep with a toggling stall.
    clear_colour = 3'd5;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_clear(5);
    cyc = 0;
    while (clear_busy === 1'b1 && cyc < 40000) begin
      fb_stall = ~fb_stall;
      tick();
      cyc++;
    end
    fb_stall = 1'b0;
    tick();
    chk("t5_all_written", 32'(exp_q.size()), 32'd0);
    chk("t5_duration_ok", 32'(cyc >= 38300 && cyc <= 38500), 32'd1);

    // 6: reset in the middle of a sweep.
    clear_colour = 3'd3;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_clear(3);
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr == 15'd500) && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_reached_500", 32'(fb_addr), 32'd500);
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    clip_model = 0;
    chk("t6_we", 32'(fb_we), 32'd0);
    chk("t6_busy", 32'(clear_busy), 32'd0);
    chk("t6_ready", 32'(plot_ready), 32'd1);
`ifdef PLOT_SINK_CLIP_COUNT_EN
    chk("t6_clip", 32'(clip_count), 32'd0);
`endif
    reset_n = 1'b1;
    tick();
    send(5, 2, 6);
    tick();
    chk("t6_plot_addr", 32'(fb_addr), 32'd325);
    wait_drain("t6_drain");

    // 7: randomized requests and stalls.
    for (int c = 0; c < 400; c++) begin
      if (plot_valid !== 1'b1 && $urandom_range(0, 2) != 0) begin
        plot_valid  = 1'b1;
        plot_x      = 8'($urandom_range(0, 175));
        plot_y      = 7'($urandom_range(0, 127));
        plot_colour = 3'($urandom_range(0, 7));
      end
      fb_stall = ($urandom_range(0, 3) == 0);
      rdy = plot_ready;
      tick();
      if (rdy && plot_valid) plot_valid = 1'b0;
    end
    fb_stall = 1'b0;
    wait_drain("t7_drain");
`ifdef PLOT_SINK_CLIP_COUNT_EN
    chk("t7_clip", 32'(clip_count), 32'(clip_model));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
